prbs_randomizer_par: RTL
========================

# prbs_randomizer_par

Parametrised, parallel successor to the serial 15-bit LFSR randomizer.
- Scrambles DATA_W bits per clock against a Fibonacci PRBS with configurable length and taps, over a valid/ready stream.
- Automatically reloads the seed every BLOCK_BITS bits, so framed transport blocks (e.g. 96-bit test frames or 188-byte packets) are randomized independently.
- Sits between the framing stage and the channel encoder in the transmit chain; one instance with an identical seed descrambles at the receiver.

## Interface
- LFSR_W, 15, PRBS register length (≥ 2).
- TAPS, 15'h0003, feedback mask; bit k set means state[k] enters the XOR.
- DEF_SEED, 15'b100101010000000, seed value applied at reset.
- DATA_W, 8, bits per beat (1..64).
- BLOCK_BITS, 96, bits per block before auto-reseed; must be a multiple of DATA_W.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- seed_in  in  LFSR_W  seed value, sampled on seed_load.
- seed_load  in  1  loads seed_in into the seed register and the LFSR, and clears the beat counter.
- in_valid / in_ready  in / out  1  input handshake.
- in_data  in  DATA_W  payload; bit 0 is processed first.
- out_valid / out_ready  out / in  1  output handshake.
- out_data  out  DATA_W  scrambled payload.
- out_last  out  1  marks the final beat of a block.
- busy  out  1  high in S_RUN.

## Operation
- The block follows the channel-encoder convention: reset is asynchronous and active-high; clock is `clk`, reset is `rst`.
- LFSR step, applied per bit:
  - fb = ^(state & TAPS)
  - out bit = in bit ^ fb
  - state <= {fb, state[LFSR_W-1:1]}
- For a beat, DATA_W steps are unrolled combinationally. Bit i uses the state after i steps.
- FSM:
  - S_IDLE: in_ready = 0. On seed_load → S_RUN.
  - S_RUN: a beat is accepted when in_valid && in_ready. Accepting a beat advances the LFSR by DATA_W and increments beat_cnt.
  - S_RUN, final beat: when beat_cnt == BLOCK_BITS/DATA_W − 1, the beat is accepted with out_last set. The LFSR then reloads from the seed register and beat_cnt returns to 0.
- seed_load in S_RUN restarts the block from seed_in.
- seed_load has priority over a beat:
  - in_ready is forced low that cycle, so no beat is lost.
  - The loaded seed applies to the next accepted beat.
- Output register:
  - in_ready = (state == S_RUN) && !seed_load && (!out_valid || out_ready).
  - out_valid holds, with data stable, until out_ready.
- The data path is combinational XOR against the register state, so scrambling twice with the same seed returns the original data.
- Widths:
  - beat_cnt is $clog2(BLOCK_BITS/DATA_W), with a minimum of 1.
  - TAPS and seed are exactly LFSR_W bits.
- All-zero seed: accepted, but the PRBS stays 0. This case is a configuration error, not detected in RTL.

## Timing
- Reset values:
  - S_IDLE, state = seed register = DEF_SEED, beat_cnt = 0.
  - out_valid = 0, out_data = 0, out_last = 0, busy = 0.
  - in_ready = 0.
- Latency: 1 cycle from acceptance to out_valid.
- Throughput: 1 beat/cycle when out_ready stays high.
- Back-pressure: out_ready low with out_valid high stalls the LFSR and the counter. No state advances.
- Reset mid-block:
  - Output is discarded immediately.
  - The block returns to S_IDLE with DEF_SEED.
  - A new seed_load is required.
- Block wrap and seed_load in the same cycle: seed_load wins. The new seed is used and beat_cnt = 0.

## Configuration
- PRBS_RAND_BYPASS_EN defined:
  - Adds input `bypass` (1 bit).
  - While bypass = 1, accepted beats pass unchanged. The LFSR and beat_cnt hold, and out_last is 0.
- PRBS_RAND_BYPASS_EN undefined: the `bypass` port is absent and every beat is scrambled.

## Structure
- Shared package prbs_pkg holds:
  - the DVB constants (LFSR_W = 15, TAPS = 15'h0003, DEF_SEED = 15'b100101010000000);
  - the FSM state enum {S_IDLE, S_RUN};
  - the function prbs_step_n, which returns the next state and the keystream for n bits.
- One sub-module, prbs_keystream: combinational, computing state plus DATA_W keystream bits, reused by the descrambler.

## Test plan
- Default seed via seed_load, in_data = 0x00 for two beats → out_data = 0xC0 then 0x6F (0x03, 0xF6 MSB-first).
- DATA_W = 8, BLOCK_BITS = 96, 13 zero beats:
  - out_last is set on beat 12.
  - Beat 13 restarts at 0xC0.
- Scramble a random 96-bit frame, then feed the result back through the block with the same seed → the original frame is recovered bit-exactly.
- Hold out_ready low for 5 cycles mid-block → out_data is stable, in_ready = 0, and the sequence resumes with no skipped keystream.
- seed_load asserted with in_valid at beat 4 → in_ready = 0 that cycle, and the next accepted beat is scrambled from the new seed with beat_cnt = 0.
- Assert rst asynchronously mid-beat → out_valid drops before the next edge, and in_ready stays 0 until seed_load. With PRBS_RAND_BYPASS_EN, bypass = 1 passes 0xA5 unchanged.

Source files
------------

// File: rtl/prbs_pkg.sv
// prbs_pkg -- shared definitions for the parallel PRBS randomizer family.
//   DVB_LFSR_W / DVB_TAPS / DVB_SEED : reference DVB randomizer configuration
//   prbs_state_e                     : control FSM states
//   prbs_step_n                      : advances a DVB-sized LFSR by n bits and
//                                      returns the new state plus the keystream
package prbs_pkg;

  localparam int DVB_LFSR_W = 15;
  localparam logic [DVB_LFSR_W-1:0] DVB_TAPS = 15'h0003;
  localparam logic [DVB_LFSR_W-1:0] DVB_SEED = 15'b100101010000000;

  // Widest keystream prbs_step_n can return in one call.
  localparam int MAX_STEP_N = 64;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } prbs_state_e;

  typedef struct packed {
    logic [DVB_LFSR_W-1:0] state;
    logic [MAX_STEP_N-1:0] ks;
  } prbs_step_t;

  // Fibonacci step repeated n times; ks[i] is the feedback bit of step i,
  // i.e. the keystream bit that scrambles payload bit i.
  function automatic prbs_step_t prbs_step_n(input logic [DVB_LFSR_W-1:0] state,
                                             input int n);
    prbs_step_t r;
    logic fb;
    r.state = state;
    r.ks    = '0;
    for (int i = 0; i < MAX_STEP_N; i++) begin
      if (i < n) begin
        fb      = ^(r.state & DVB_TAPS);
        r.ks[i] = fb;
        r.state = {fb, r.state[DVB_LFSR_W-1:1]};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/prbs_randomizer_par_if.sv
// prbs_randomizer_par_if -- stream + seed-control bundle of the randomizer.
//   seed_in/seed_load : seed value and load strobe
//   in_valid/in_ready/in_data : input beat handshake
//   out_valid/out_ready/out_data/out_last : output beat handshake, block end marker
//   busy : randomizer is running
// master = upstream/downstream environment, slave = randomizer.
interface prbs_randomizer_par_if #(
  parameter int LFSR_W = 15,
  parameter int DATA_W = 8
);
  logic [LFSR_W-1:0] seed_in;
  logic              seed_load;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;

  modport master (
    output seed_in, seed_load, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );

  modport slave (
    input  seed_in, seed_load, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/prbs_keystream.sv
// prbs_keystream -- combinational DATA_W-step unroll of a Fibonacci LFSR.
//   state_in  : current register value
//   ks        : keystream, ks[i] is produced after i steps (bit 0 first)
//   state_out : register value after DATA_W steps
// Shared by the scrambler and the descrambler (same logic on both ends).
module prbs_keystream #(
  parameter int                 LFSR_W = 15,
  parameter logic [LFSR_W-1:0]  TAPS   = 15'h0003,
  parameter int                 DATA_W = 8
) (
  input  logic [LFSR_W-1:0] state_in,
  output logic [DATA_W-1:0] ks,
  output logic [LFSR_W-1:0] state_out
);

  // st[k] is the register after k steps.
  logic [DATA_W:0][LFSR_W-1:0] st;

  assign st[0] = state_in;

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_step
    logic fb;
    assign fb        = ^(st[gi] & TAPS);
    assign ks[gi]    = fb;
    assign st[gi+1]  = {fb, st[gi][LFSR_W-1:1]};
  end

  assign state_out = st[DATA_W];

endmodule

// File: rtl/prbs_randomizer_par.sv
// prbs_randomizer_par -- parallel PRBS randomizer with per-block auto-reseed.
//   clk, rst : clock (rising edge) and asynchronous active-high reset
//   bus      : prbs_randomizer_par_if.slave (seed control, in/out streams, busy)
//   bypass   : only when PRBS_RAND_BYPASS_EN is defined; passes beats unchanged
// Each accepted beat is XORed with DATA_W keystream bits and registered; after
// BLOCK_BITS bits the LFSR reloads from the seed register so every block is
// scrambled independently. Running the output through a second instance with
// the same seed restores the original data.
module prbs_randomizer_par
  import prbs_pkg::*;
#(
  parameter int                 LFSR_W     = prbs_pkg::DVB_LFSR_W,
  parameter logic [LFSR_W-1:0]  TAPS       = prbs_pkg::DVB_TAPS,
  parameter logic [LFSR_W-1:0]  DEF_SEED   = prbs_pkg::DVB_SEED,
  parameter int                 DATA_W     = 8,
  parameter int                 BLOCK_BITS = 96
) (
  input  logic clk,
  input  logic rst,
`ifdef PRBS_RAND_BYPASS_EN
  input  logic bypass,
`endif
  prbs_randomizer_par_if.slave bus
);

  localparam int BEATS = BLOCK_BITS / DATA_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  prbs_state_e       state_reg, state_next;
  logic [LFSR_W-1:0] lfsr_reg;
  logic [LFSR_W-1:0] seed_reg;
  logic [CNT_W-1:0]  beat_cnt_reg;
  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic              out_last_reg;

  logic              in_ready;
  logic              accept;
  logic              byp;
  logic [DATA_W-1:0] ks;
  logic [LFSR_W-1:0] lfsr_adv;

`ifdef PRBS_RAND_BYPASS_EN
  assign byp = bypass;
`else
  assign byp = 1'b0;
`endif

  prbs_keystream #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS),
    .DATA_W (DATA_W)
  ) u_keystream (
    .state_in  (lfsr_reg),
    .ks        (ks),
    .state_out (lfsr_adv)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // FSM next state and handshake outputs. seed_load blocks acceptance for the
  // cycle so that no beat is scrambled with a key that is about to change.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (bus.seed_load) state_next = S_RUN;
      end
      S_RUN: begin
        in_ready = !bus.seed_load && (!out_valid_reg || bus.out_ready);
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign accept = bus.in_valid && in_ready;

  // LFSR, seed register and beat counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_reg     <= DEF_SEED;
      seed_reg     <= DEF_SEED;
      beat_cnt_reg <= '0;
    end else if (bus.seed_load) begin
      lfsr_reg     <= bus.seed_in;
      seed_reg     <= bus.seed_in;
      beat_cnt_reg <= '0;
    end else if (accept && !byp) begin
      if (beat_cnt_reg == LAST_BEAT) begin
        lfsr_reg     <= seed_reg;
        beat_cnt_reg <= '0;
      end else begin
        lfsr_reg     <= lfsr_adv;
        beat_cnt_reg <= beat_cnt_reg + 1'b1;
      end
    end
  end

  // Output register: loads on acceptance, otherwise holds until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= byp ? bus.in_data : (bus.in_data ^ ks);
      out_last_reg  <= !byp && (beat_cnt_reg == LAST_BEAT);
    end else if (bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_last  = out_last_reg;
  assign bus.busy      = (state_reg == S_RUN);

endmodule
